dsp_pipe_ctrl: RTL and testbench
================================

DSP_PIPE_CTRL -- requirements
Module: dsp_pipe_ctrl

Drives the clk_en and rst inputs of the DSP slice's optional pipeline registers. It tracks data validity through the enabled stages and provides a valid/ready handshake at both ends.

Interface
REQ-001 Parameter S1REG, default 1: stage-1 registers (A0/B0/C/D/OPMODE/CARRYIN) present, 0/1.
REQ-002 Parameter S2REG, default 1: stage-2 registers (A1/B1) present, 0/1.
REQ-003 Parameter S3REG, default 1: stage-3 registers (M/CARRYIN) present, 0/1.
REQ-004 Parameter S4REG, default 1: stage-4 registers (P/CARRYOUT) present, 0/1.
REQ-005 Parameter INIT_CYCLES, default 2: cycles rst_pipe is held after reset release, range 1..15.
REQ-006 clk  input  1: single clock; all logic on its rising edge.
REQ-007 rst  input  1: reset, synchronous, active-high.
REQ-008 in_valid  input  1: upstream operand set valid.
REQ-009 in_ready  output  1: controller accepts operands this cycle.
REQ-010 out_valid  output  1: slice output holds a valid result.
REQ-011 out_ready  input  1: downstream consumes the result.
REQ-012 flush  input  1: single-cycle request to discard all in-flight data.
REQ-013 ce_s1, ce_s2, ce_s3, ce_s4  output  1 each: clock enables to stage 1..4 registers.
REQ-014 rst_pipe  output  1: synchronous reset to all slice pipeline registers.
REQ-015 inflight  output  3: number of valid entries currently in the pipeline.
REQ-016 busy  output  1: high when state is not RUN or inflight is nonzero.

Function
REQ-017 Latency L SHALL equal S1REG+S2REG+S3REG+S4REG, range 0..4.
REQ-018 FSM states SHALL be INIT, RUN and FLUSH.
REQ-019 INIT SHALL be entered from rst and SHALL go to RUN after INIT_CYCLES cycles, using a 4-bit counter.
REQ-020 RUN SHALL go to FLUSH when flush=1.
REQ-021 FLUSH SHALL return to RUN after exactly 1 cycle.
REQ-022 rst_pipe SHALL be 1 in INIT and FLUSH and 0 in RUN.
REQ-023 Stage activity: vld[k] SHALL exist only for stages with SkREG=1; a stage with SkREG=0 has its ce_sk tied to 0.
REQ-024 out_valid SHALL equal vld of the last enabled stage.
REQ-025 adv SHALL equal (state==RUN) and not (out_valid and not out_ready); the pipeline uses a global stall with no bubble compression.
REQ-026 ce_sk SHALL equal adv AND SkREG, for each stage k.
REQ-027 in_ready SHALL equal adv when L>0.
REQ-028 When adv=1, the first enabled vld SHALL load in_valid, and each later enabled vld SHALL load its predecessor.
REQ-029 When adv=0, all vld SHALL hold.
REQ-030 A transfer SHALL occur only when in_valid and in_ready are both high; out_valid, once high, SHALL remain high until out_ready=1.
REQ-031 When L=0: out_valid SHALL equal in_valid and in_ready SHALL equal out_ready while in RUN, both 0 otherwise; inflight SHALL be 0; all ce SHALL be 0.
REQ-032 inflight SHALL equal the popcount of all vld bits and SHALL never exceed L.
REQ-033 Simultaneous out_ready and in_valid with a full pipeline SHALL advance the pipeline, accept the new operand and retire the oldest result in the same cycle.
REQ-034 FLUSH SHALL clear all vld bits.
REQ-035 In FLUSH, in_ready, out_valid and all ce SHALL be 0.
REQ-036 flush SHALL be ignored in INIT and in FLUSH.
REQ-037 A flush coinciding with an accept SHALL discard that operand.

Reset
REQ-038 When rst=1, the next edge SHALL set: state=INIT, counter=0, vld=0, rst_pipe=1, all ce=0, in_ready=0, out_valid=0, inflight=0, busy=1.
REQ-039 rst SHALL override flush and any handshake in the same cycle.
REQ-040 Reset mid-operation SHALL drop all in-flight data, and no out_valid SHALL appear for it.
REQ-041 rst_pipe SHALL be registered and glitch-free.

Verification
REQ-042 Defaults; rst 1 cycle, then release -> rst_pipe=1 for 2 cycles, then RUN; busy=0, in_ready=1.
REQ-043 Defaults (L=4), out_ready=1, one in_valid pulse at cycle t -> out_valid=1 at cycle t+4 only; inflight goes 1,1,1,1,0.
REQ-044 Defaults, continuous in_valid, out_ready=0 -> out_valid first high after 4 cycles, then in_ready=0 and all ce=0, inflight=4; out_ready=1 for 1 cycle -> exactly one result retires and one new operand is accepted.
REQ-045 S2REG=0, S3REG=0 (L=2) -> result 2 cycles after accept; ce_s2=ce_s3=0 always.
REQ-046 Defaults with inflight=3, flush pulse -> 1 cycle with rst_pipe=1, inflight=0, in_ready=0, then RUN; no out_valid for the flushed data.
REQ-047 All SkREG=0 -> out_valid follows in_valid combinationally in RUN; rst held -> out_valid=0.

Source files
------------

// File: rtl/dsp_pipe_ctrl.sv
// Purpose: clock-enable / reset controller for a DSP slice's optional pipeline registers, tracking valid data per stage.
// Latency: S1REG+S2REG+S3REG+S4REG cycles from accept to out_valid (combinational pass-through when no stage is enabled).
// Backpressure: global stall; a held result with out_ready low freezes every stage and drops in_ready, with no bubble compression.
module dsp_pipe_ctrl #(
  parameter int S1REG       = 1,
  parameter int S2REG       = 1,
  parameter int S3REG       = 1,
  parameter int S4REG       = 1,
  parameter int INIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic       flush,
  output logic       ce_s1,
  output logic       ce_s2,
  output logic       ce_s3,
  output logic       ce_s4,
  output logic       rst_pipe,
  output logic [2:0] inflight,
  output logic       busy
);

  // Bit k marks stage k+1 as physically present in the slice.
  localparam logic [3:0] STG_EN   = {S4REG != 0, S3REG != 0, S2REG != 0, S1REG != 0};
  localparam bit         HAS_PIPE = (STG_EN != 4'b0000);
  // INIT lasts INIT_CYCLES cycles; the counter runs 0 .. INIT_CYCLES-1.
  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] vld_q, vld_d;
  logic       run;
  logic       flush_take;
  logic       pipe_ov;
  logic       adv;
  logic       carry;

  // Next-state logic: INIT counts out the slice reset, RUN moves data, FLUSH is a single clearing cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RUN: begin
        if (flush) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // A flush arriving here is ignored; always one cycle only.
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State register plus rst_pipe, which is registered from the next state so it never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT;
      cnt_q    <= 4'd0;
      rst_pipe <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rst_pipe <= (state_d != ST_RUN);
    end
  end

  // Stall decision: the last enabled stage drives out_valid; a result nobody takes freezes everything.
  always_comb begin
    run        = (state_q == ST_RUN);
    flush_take = run & flush;
    pipe_ov    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (STG_EN[k]) pipe_ov = vld_q[k];
    end
    adv = run & ~(pipe_ov & ~out_ready);
  end

  // Valid chain: each present stage loads from the nearest present stage upstream (or in_valid).
  always_comb begin
    vld_d = vld_q;
    carry = in_valid;
    if (flush_take || state_q == ST_FLUSH) begin
      // Clearing on the flush edge also discards an operand accepted in that same cycle.
      vld_d = 4'b0000;
    end else if (adv) begin
      for (int k = 0; k < 4; k++) begin
        if (STG_EN[k]) begin
          vld_d[k] = carry;
          carry    = vld_q[k];
        end
      end
    end
  end

  // Valid bits for absent stages are masked so they stay zero forever.
  always_ff @(posedge clk) begin
    if (rst) vld_q <= 4'b0000;
    else     vld_q <= vld_d & STG_EN;
  end

  // Occupancy is the popcount of the valid chain.
  always_comb begin
    inflight = 3'd0;
    for (int k = 0; k < 4; k++) begin
      inflight = inflight + {2'b00, vld_q[k]};
    end
  end

  assign ce_s1 = adv & STG_EN[0];
  assign ce_s2 = adv & STG_EN[1];
  assign ce_s3 = adv & STG_EN[2];
  assign ce_s4 = adv & STG_EN[3];

  // With no registers the controller is a straight wire gated by RUN.
  assign in_ready  = HAS_PIPE ? adv     : (run & out_ready);
  assign out_valid = HAS_PIPE ? pipe_ov : (run & in_valid);
  assign busy      = (state_q != ST_RUN) | (inflight != 3'd0);

endmodule

// File: tb/tb_dsp_pipe_ctrl.sv
// Directed bench for dsp_pipe_ctrl: default (L=4), L=2 (S2REG=S3REG=0) and L=0 instances share stimulus.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later, well before the rising edge.
// Each test task compares observed outputs against hand-derived values.
module tb_dsp_pipe_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst       = 1'b1;
  logic in_valid  = 1'b0;
  logic out_ready = 1'b0;
  logic flush     = 1'b0;

  logic       d_in_ready, d_out_valid, d_ce1, d_ce2, d_ce3, d_ce4, d_rst_pipe, d_busy;
  logic [2:0] d_inflight;
  logic       m_in_ready, m_out_valid, m_ce1, m_ce2, m_ce3, m_ce4, m_rst_pipe, m_busy;
  logic [2:0] m_inflight;
  logic       z_in_ready, z_out_valid, z_ce1, z_ce2, z_ce3, z_ce4, z_rst_pipe, z_busy;
  logic [2:0] z_inflight;

  int errors = 0;
  int checks = 0;

  dsp_pipe_ctrl u_d (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready), .out_valid(d_out_valid),
    .out_ready(out_ready), .flush(flush), .ce_s1(d_ce1), .ce_s2(d_ce2), .ce_s3(d_ce3), .ce_s4(d_ce4),
    .rst_pipe(d_rst_pipe), .inflight(d_inflight), .busy(d_busy)
  );

  dsp_pipe_ctrl #(.S2REG(0), .S3REG(0)) u_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .out_valid(m_out_valid),
    .out_ready(out_ready), .flush(flush), .ce_s1(m_ce1), .ce_s2(m_ce2), .ce_s3(m_ce3), .ce_s4(m_ce4),
    .rst_pipe(m_rst_pipe), .inflight(m_inflight), .busy(m_busy)
  );

  dsp_pipe_ctrl #(.S1REG(0), .S2REG(0), .S3REG(0), .S4REG(0)) u_z (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_in_ready), .out_valid(z_out_valid),
    .out_ready(out_ready), .flush(flush), .ce_s1(z_ce1), .ce_s2(z_ce2), .ce_s3(z_ce3), .ce_s4(z_ce4),
    .rst_pipe(z_rst_pipe), .inflight(z_inflight), .busy(z_busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
    tick(); #1;
    checks++; if (d_rst_pipe !== 1'b1) begin errors++; $display("FAIL reset_rst_pipe got=%b want=1", d_rst_pipe); end
    checks++; if (d_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", d_in_ready); end
    checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", d_out_valid); end
    checks++; if (d_inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight got=%0d want=0", d_inflight); end
    checks++; if (d_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b want=1", d_busy); end
    checks++; if ({d_ce1, d_ce2, d_ce3, d_ce4} !== 4'b0000) begin errors++; $display("FAIL reset_ce got=%b want=0000", {d_ce1, d_ce2, d_ce3, d_ce4}); end
    rst = 1'b0; flush = 1'b0;
    tick(); #1;
    checks++; if (d_rst_pipe !== 1'b1) begin errors++; $display("FAIL init2_rst_pipe got=%b want=1", d_rst_pipe); end
    checks++; if (d_in_ready !== 1'b0) begin errors++; $display("FAIL init2_in_ready got=%b want=0", d_in_ready); end
    tick(); #1;
    checks++; if (d_rst_pipe !== 1'b0) begin errors++; $display("FAIL run_rst_pipe got=%b want=0", d_rst_pipe); end
    checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL run_busy got=%b want=0", d_busy); end
    checks++; if (d_in_ready !== 1'b1) begin errors++; $display("FAIL run_in_ready got=%b want=1", d_in_ready); end
    checks++; if (d_ce1 !== 1'b1) begin errors++; $display("FAIL run_ce1 got=%b want=1", d_ce1); end
    checks++; if (z_in_ready !== 1'b1) begin errors++; $display("FAIL l0_in_ready got=%b want=1", z_in_ready); end
  endtask

  task automatic test_single();
    tick(); in_valid = 1'b1; out_ready = 1'b1; #1;
    checks++; if (d_in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got=%b want=1", d_in_ready); end
    checks++; if (z_out_valid !== 1'b1) begin errors++; $display("FAIL l0_follow got=%b want=1", z_out_valid); end
    for (int i = 1; i <= 5; i++) begin
      tick(); in_valid = 1'b0; #1;
      checks++; if (d_inflight !== ((i <= 4) ? 3'd1 : 3'd0)) begin errors++; $display("FAIL single_inflight t+%0d got=%0d want=%0d", i, d_inflight, (i <= 4) ? 1 : 0); end
      checks++; if (d_out_valid !== (i == 4)) begin errors++; $display("FAIL single_out_valid t+%0d got=%b want=%b", i, d_out_valid, i == 4); end
      checks++; if (m_out_valid !== (i == 2)) begin errors++; $display("FAIL l2_out_valid t+%0d got=%b want=%b", i, m_out_valid, i == 2); end
      checks++; if ({m_ce2, m_ce3} !== 2'b00) begin errors++; $display("FAIL l2_ce23 t+%0d got=%b want=00", i, {m_ce2, m_ce3}); end
      checks++; if (z_out_valid !== 1'b0) begin errors++; $display("FAIL l0_idle t+%0d got=%b want=0", i, z_out_valid); end
    end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; out_ready = 1'b0; #1;
    checks++; if (d_in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready0 got=%b want=1", d_in_ready); end
    for (int i = 1; i <= 4; i++) begin
      tick(); #1;
      checks++; if (d_inflight !== 3'(i)) begin errors++; $display("FAIL bp_fill_inflight c%0d got=%0d want=%0d", i, d_inflight, i); end
      checks++; if (d_out_valid !== (i == 4)) begin errors++; $display("FAIL bp_fill_out_valid c%0d got=%b want=%b", i, d_out_valid, i == 4); end
    end
    checks++; if (d_in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_in_ready got=%b want=0", d_in_ready); end
    checks++; if ({d_ce1, d_ce2, d_ce3, d_ce4} !== 4'b0000) begin errors++; $display("FAIL bp_stall_ce got=%b want=0000", {d_ce1, d_ce2, d_ce3, d_ce4}); end
    tick(); #1;
    checks++; if (d_out_valid !== 1'b1 || d_inflight !== 3'd4) begin errors++; $display("FAIL bp_hold got=%b/%0d want=1/4", d_out_valid, d_inflight); end
    out_ready = 1'b1; #1;
    checks++; if (d_in_ready !== 1'b1 || d_ce4 !== 1'b1) begin errors++; $display("FAIL bp_release got=%b/%b want=1/1", d_in_ready, d_ce4); end
    tick(); out_ready = 1'b0; #1;
    checks++; if (d_inflight !== 3'd4) begin errors++; $display("FAIL bp_swap_inflight got=%0d want=4", d_inflight); end
    checks++; if (d_out_valid !== 1'b1 || d_in_ready !== 1'b0) begin errors++; $display("FAIL bp_swap_hs got=%b/%b want=1/0", d_out_valid, d_in_ready); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (d_out_valid !== 1'b1 || d_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_hs c%0d got=%b/%b want=1/1", i, d_out_valid, d_in_ready); end
      checks++; if (d_inflight !== 3'd4) begin errors++; $display("FAIL b2b_inflight c%0d got=%0d want=4", i, d_inflight); end
      tick();
    end
    in_valid = 1'b0;
    repeat (5) tick();
    #1;
    checks++; if (d_inflight !== 3'd0 || d_busy !== 1'b0) begin errors++; $display("FAIL drain got=%0d/%b want=0/0", d_inflight, d_busy); end
    checks++; if (m_inflight !== 3'd0) begin errors++; $display("FAIL l2_drain got=%0d want=0", m_inflight); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0; flush = 1'b1; #1;
    checks++; if (d_inflight !== 3'd3) begin errors++; $display("FAIL flush_pre_inflight got=%0d want=3", d_inflight); end
    tick(); flush = 1'b0; #1;
    checks++; if (d_rst_pipe !== 1'b1) begin errors++; $display("FAIL flush_rst_pipe got=%b want=1", d_rst_pipe); end
    checks++; if (d_inflight !== 3'd0) begin errors++; $display("FAIL flush_inflight got=%0d want=0", d_inflight); end
    checks++; if (d_in_ready !== 1'b0 || d_out_valid !== 1'b0) begin errors++; $display("FAIL flush_hs got=%b/%b want=0/0", d_in_ready, d_out_valid); end
    checks++; if ({d_ce1, d_ce2, d_ce3, d_ce4} !== 4'b0000 || d_busy !== 1'b1) begin errors++; $display("FAIL flush_ce_busy got=%b/%b want=0000/1", {d_ce1, d_ce2, d_ce3, d_ce4}, d_busy); end
    tick(); #1;
    checks++; if (d_rst_pipe !== 1'b0 || d_in_ready !== 1'b1) begin errors++; $display("FAIL flush_back got=%b/%b want=0/1", d_rst_pipe, d_in_ready); end
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      checks++; if (d_out_valid !== 1'b0 || m_out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost c%0d got=%b/%b want=0/0", i, d_out_valid, m_out_valid); end
    end
  endtask

  task automatic test_flush_accept();
    in_valid = 1'b1; flush = 1'b1; #1;
    checks++; if (d_in_ready !== 1'b1) begin errors++; $display("FAIL fa_in_ready got=%b want=1", d_in_ready); end
    tick(); in_valid = 1'b0; #1;
    checks++; if (d_rst_pipe !== 1'b1 || d_inflight !== 3'd0) begin errors++; $display("FAIL fa_flush got=%b/%0d want=1/0", d_rst_pipe, d_inflight); end
    tick(); flush = 1'b0; #1;
    checks++; if (d_rst_pipe !== 1'b0 || d_in_ready !== 1'b1) begin errors++; $display("FAIL fa_ignored_in_flush got=%b/%b want=0/1", d_rst_pipe, d_in_ready); end
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      checks++; if (d_out_valid !== 1'b0 || d_inflight !== 3'd0) begin errors++; $display("FAIL fa_ghost c%0d got=%b/%0d want=0/0", i, d_out_valid, d_inflight); end
    end
  endtask

  task automatic test_l0();
    in_valid = 1'b1; out_ready = 1'b0; #1;
    checks++; if (z_out_valid !== 1'b1 || z_in_ready !== 1'b0) begin errors++; $display("FAIL l0_hs_a got=%b/%b want=1/0", z_out_valid, z_in_ready); end
    checks++; if (z_inflight !== 3'd0 || {z_ce1, z_ce2, z_ce3, z_ce4} !== 4'b0000) begin errors++; $display("FAIL l0_static got=%0d/%b want=0/0000", z_inflight, {z_ce1, z_ce2, z_ce3, z_ce4}); end
    in_valid = 1'b0; out_ready = 1'b1; #1;
    checks++; if (z_out_valid !== 1'b0 || z_in_ready !== 1'b1) begin errors++; $display("FAIL l0_hs_b got=%b/%b want=0/1", z_out_valid, z_in_ready); end
  endtask

  task automatic test_midreset();
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      checks++; if (d_out_valid !== 1'b0 || d_inflight !== 3'd0 || d_rst_pipe !== 1'b1) begin errors++; $display("FAIL mr_held c%0d got=%b/%0d/%b want=0/0/1", i, d_out_valid, d_inflight, d_rst_pipe); end
      checks++; if (z_out_valid !== 1'b0) begin errors++; $display("FAIL mr_l0 c%0d got=%b want=0", i, z_out_valid); end
    end
    rst = 1'b0; in_valid = 1'b0;
    repeat (2) tick();
    #1;
    checks++; if (d_rst_pipe !== 1'b0 || d_busy !== 1'b0) begin errors++; $display("FAIL mr_run got=%b/%b want=0/0", d_rst_pipe, d_busy); end
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL mr_ghost c%0d got=%b want=0", i, d_out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_flush_accept();
    test_l0();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

endmodule
